// File: rtl/muldiv_unit_pkg.sv
// Shared widths, op/state encodings and result selection for the multiply/divide unit.
// Combinational helpers only; no timing or flow-control behaviour lives here.
package muldiv_unit_pkg;

  localparam int DATAWIDTH = 16;
  localparam int REGWIDTH  = 4;
  localparam int ITERS     = 16;

  typedef enum logic [1:0] {
    OP_MULLO = 2'b00,
    OP_MULHI = 2'b01,
    OP_DIVQ  = 2'b10,
    OP_DIVR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The product and the {remainder, quotient} pair share one layout, so the high half
  // is MULHI or DIVR and the low half is MULLO or DIVQ.
  function automatic logic [DATAWIDTH-1:0] select_result(
    input logic                     hi_sel,
    input logic [2*DATAWIDTH-1:0]   acc
  );
    return hi_sel ? acc[2*DATAWIDTH-1:DATAWIDTH] : acc[DATAWIDTH-1:0];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request and writeback bundle between the pipeline/regfile and the multiply/divide unit.
// The master drives operands and start; the slave returns busy and the writeback strobe.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic                 start;
  logic [1:0]           op;
  logic [DATAWIDTH-1:0] a;
  logic [DATAWIDTH-1:0] b;
  logic [REGWIDTH-1:0]  dst;
  logic                 busy;
  logic                 wb_write;
  logic [REGWIDTH-1:0]  wb_rdst;
  logic [DATAWIDTH-1:0] wb_data;

  modport master (
    output start, op, a, b, dst,
    input  busy, wb_write, wb_rdst, wb_data
  );

  modport slave (
    input  start, op, a, b, dst,
    output busy, wb_write, wb_rdst, wb_data
  );

endinterface

// File: rtl/muldiv_unit_core.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per step, 16 steps.
// No backpressure; the controller owns load/step and reads result_next on the last step.
module muldiv_core
  import muldiv_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [1:0]           op,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [4:0]           count,
  output logic [DATAWIDTH-1:0] result_next
);

  localparam int DW = DATAWIDTH;

  logic [2*DW-1:0] acc_q;
  logic [DW-1:0]   opnd_q;
  logic            div_q;
  logic            hi_q;

  logic [DW:0]     mul_sum;
  logic [DW-1:0]   div_diff;
  logic [2*DW-1:0] mul_step;
  logic [2*DW-1:0] div_step;
  logic [2*DW-1:0] acc_step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, opnd_q};
    mul_step = acc_q[0] ? {mul_sum, acc_q[DW-1:1]} : {1'b0, acc_q[2*DW-1:1]};

    // Trial subtract on the shifted remainder; a fitting difference is always below the
    // divisor, so 16 bits hold it without loss.
    div_diff = acc_q[2*DW-2:DW-1] - opnd_q;
    if (acc_q[2*DW-1:DW-1] >= {1'b0, opnd_q}) begin
      div_step = {div_diff, acc_q[DW-2:0], 1'b1};
    end else begin
      div_step = {acc_q[2*DW-2:0], 1'b0};
    end

    acc_step    = div_q ? div_step : mul_step;
    result_next = select_result(hi_q, acc_step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      hi_q   <= 1'b0;
      count  <= '0;
    end else if (load) begin
      div_q  <= (op == OP_DIVQ) || (op == OP_DIVR);
      hi_q   <= (op == OP_MULHI) || (op == OP_DIVR);
      acc_q  <= op[1] ? {{DW{1'b0}}, a} : {{DW{1'b0}}, b};
      opnd_q <= op[1] ? b : a;
      count  <= '0;
    end else if (step) begin
      acc_q <= acc_step;
      count <= count + 5'd1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide controller: IDLE/BUSY/DONE FSM plus registered writeback, 17 cycles start to strobe.
// start is ignored while busy (no queuing); the pipeline is expected to stall on busy.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  io
);

  state_e               state_q;
  state_e               state_d;
  logic                 load;
  logic                 step;
  logic                 wb_set;
  logic [REGWIDTH-1:0]  dst_q;
  logic [4:0]           count;
  logic [DATAWIDTH-1:0] result_next;
  logic                 wb_write_q;
  logic [REGWIDTH-1:0]  wb_rdst_q;
  logic [DATAWIDTH-1:0] wb_data_q;

  muldiv_core u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .step        (step),
    .op          (io.op),
    .a           (io.a),
    .b           (io.b),
    .count       (count),
    .result_next (result_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    wb_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io.start) begin
          load    = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        step = 1'b1;
        if (count == 5'(ITERS - 1)) begin
          wb_set  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q      <= '0;
      wb_write_q <= 1'b0;
      wb_rdst_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      if (load) begin
        dst_q <= io.dst;
      end
      wb_write_q <= wb_set;
      // Address and data hold after the strobe until the next result lands.
      if (wb_set) begin
        wb_rdst_q <= dst_q;
        wb_data_q <= result_next;
      end
    end
  end

  assign io.busy     = (state_q != ST_IDLE);
  assign io.wb_write = wb_write_q;
  assign io.wb_rdst  = wb_rdst_q;
  assign io.wb_data  = wb_data_q;

endmodule
